// File: rtl/rca_seq_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract: one 4-bit ripple-carry adder is stepped over the
// operand nibbles (LSB nibble first), with valid/ready handshakes on command and result.

module rca_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;

   assign c[0] = ci;
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign co = c[4];
endmodule

module rca_seq_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   input  logic             sub,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = $clog2(NIB);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             carry_q, cout_q, ovf_q;
   logic [IW-1:0]    idx_q;

   logic [3:0]       nib_a, nib_b, nib_s;
   logic             nib_co;

   assign nib_a = a_q[4*idx_q +: 4];
   assign nib_b = b_q[4*idx_q +: 4];

   rca_4bit u_rca (
      .a  (nib_a),
      .b  (nib_b),
      .ci (carry_q),
      .s  (nib_s),
      .co (nib_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         case (state)
            IDLE: if (start_valid) begin
               // Subtraction is a + ~b + 1: invert B once here, seed the carry with 1.
               a_q     <= op_a;
               b_q     <= sub ? ~op_b : op_b;
               carry_q <= sub ? 1'b1 : cin;
               idx_q   <= '0;
               state   <= RUN;
            end
            RUN: begin
               sum_q[4*idx_q +: 4] <= nib_s;
               carry_q             <= nib_co;
               if (idx_q == IW'(NIB - 1)) begin
                  cout_q <= nib_co;
                  ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[3] != a_q[WIDTH-1]);
                  idx_q  <= '0;
                  state  <= DONE;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            DONE: if (res_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign start_ready = (state == IDLE);
   assign res_valid   = (state == DONE);
   assign sum         = sum_q;
   assign cout        = cout_q;
   assign ovf         = ovf_q;
endmodule

// File: tb/tb_rca_seq_adder_ctrl.sv
// Scoreboard bench: the driver pushes arithmetic-model results, a negedge monitor
// compares every presented result (value, hold-stability and first-valid latency).

module tb_rca_seq_adder_ctrl;
   localparam int W   = 16;
   localparam int NIB = W / 4;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_valid, start_ready;
   logic [W-1:0] op_a, op_b;
   logic         cin, sub;
   logic         res_valid, res_ready;
   logic [W-1:0] sum;
   logic         cout, ovf;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   rr_rand  = 1'b0;
   bit   seen     = 1'b0;
   exp_t sb_q[$];

   rca_seq_adder_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .cin         (cin),
      .sub         (sub),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .sum         (sum),
      .cout        (cout),
      .ovf         (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", nm, got, want);
      end
   endtask

   // Reference: plain integer arithmetic, unsigned for cout, signed range for ovf.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic sb);
      exp_t e;
      int   sa, sbv, r, lim;
      logic [W:0] u;
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      lim = 1 << (W - 1);
      if (sb) begin
         u      = {1'b0, a} - {1'b0, b};
         e.cout = (a >= b);
         r      = sa - sbv;
      end else begin
         u      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
         e.cout = u[W];
         r      = sa + sbv + (ci ? 1 : 0);
      end
      e.sum = u[W-1:0];
      e.ovf = (r >= lim) || (r < -lim);
      e.acc = 0;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (rr_rand) res_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sb, input bit push);
      bit   acc = 1'b0;
      bit   rdy;
      exp_t e;
      start_valid = 1'b1;
      op_a = a; op_b = b; cin = ci; sub = sb;
      for (int t = 0; t < 60 && !acc; t++) begin
         rdy = start_ready;
         step();
         if (rdy) acc = 1'b1;
      end
      start_valid = 1'b0;
      if (!acc) begin
         chk("accept_timeout", 32'd0, 32'd1);
      end else if (push) begin
         e     = model(a, b, ci, sb);
         e.acc = cyc;
         sb_q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && res_valid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            chk("sum", 32'(sum), 32'(sb_q[0].sum));
            chk("cout", 32'(cout), 32'(sb_q[0].cout));
            chk("ovf", 32'(ovf), 32'(sb_q[0].ovf));
            chk("ready_in_done", 32'(start_ready), 32'd0);
            if (!seen) begin
               // First valid cycle follows the accept edge by NIB edges.
               chk("latency", 32'(cyc - sb_q[0].acc), 32'(NIB));
               seen = 1'b1;
            end
            if (res_ready) begin
               void'(sb_q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   task automatic drain();
      for (int t = 0; t < 300 && sb_q.size() != 0; t++) step();
      chk("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      bit   got;
      logic [W-1:0] ra, rb;
      rst_n = 1'b0; start_valid = 1'b0; op_a = '0; op_b = '0;
      cin = 1'b0; sub = 1'b0; res_ready = 1'b1;
      repeat (3) step();
      chk("rst_start_ready", 32'(start_ready), 32'd1);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
      rst_n = 1'b1;
      step();

      issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1);
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      issue(16'h8000, 16'h0001, 1'bx, 1'b1, 1'b1);
      issue(16'h0001, 16'h0002, 1'bx, 1'b1, 1'b1);
      issue(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1);
      drain();

      // Backpressure: result held while a new command waits.
      res_ready = 1'b0;
      issue(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b1);
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         if (res_valid) got = 1'b1; else step();
      end
      chk("bp_reach_done", 32'(got), 32'd1);
      start_valid = 1'b1; op_a = 16'hA5A5; op_b = 16'h5A5A; cin = 1'b1; sub = 1'b0;
      repeat (3) begin
         chk("bp_start_ready", 32'(start_ready), 32'd0);
         step();
      end
      chk("bp_still_valid", 32'(res_valid), 32'd1);
      res_ready = 1'b1;
      step();
      chk("bp_idle_after", 32'(start_ready), 32'd1);
      issue(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b1);
      drain();

      // Reset in the second RUN cycle aborts the command without a result.
      issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0);
      step();
      rst_n = 1'b0;
      #2;
      chk("abort_start_ready", 32'(start_ready), 32'd1);
      chk("abort_res_valid", 32'(res_valid), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout_ovf", {30'd0, cout, ovf}, 32'd0);
      step();
      rst_n = 1'b1;
      repeat (10) step();
      chk("abort_no_result", 32'(res_valid), 32'd0);
      chk("abort_idle", 32'(start_ready), 32'd1);

      rr_rand = 1'b1;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0: ra = 16'h8000;
            1: ra = 16'h7FFF;
            default: ra = W'($urandom);
         endcase
         rb = ($urandom_range(0, 3) == 0) ? ~ra : W'($urandom);
         issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
         repeat ($urandom_range(0, 2)) step();
      end
      rr_rand = 1'b0;
      res_ready = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1);
   end
endmodule
